spi_bus_arb: RTL and testbench
==============================

// Module: spi_bus_arb
// PURPOSE
//   Shares one 16-bit SPI master between the inertial interface (pitch reads)
//   and the A2D interface (lft_ld/rght_ld/batt conversions). Arbitrates
//   requests, launches one transaction at a time and returns the read word.
//   Drives the owner select that steers SS_n/MOSI/SCLK to the right device.
//   Inertial has priority; a starvation limit guarantees A2D service.
// PARAMETERS
//   GAP_CYCLES   4      idle clocks between transactions (0 = none)
//   STARVE_LIMIT 3      max consecutive inertial grants while a2d_req pending
//   TMO_CYCLES   4096   clocks to wait for mst_done before aborting
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   reset, asynchronous, active-low
//   inert_req   in   1   inertial request; held high until inert_done
//   inert_cmd   in   16  inertial SPI command word
//   a2d_req     in   1   A2D request; held high until a2d_done
//   a2d_cmd     in   16  A2D SPI command word
//   mst_wrt     out  1   1-clk start pulse to SPI master
//   mst_cmd     out  16  command to SPI master, stable LAUNCH..end of GAP
//   mst_done    in   1   1-clk completion pulse from SPI master
//   mst_rd      in   16  read data from SPI master, valid with mst_done
//   owner       out  1   0 = inertial, 1 = A2D; SS_n/SPI mux select
//   busy        out  1   high in every state except IDLE
//   inert_done  out  1   1-clk pulse: inertial transaction finished
//   a2d_done    out  1   1-clk pulse: A2D transaction finished
//   rd_data     out  16  registered read word, held until next completion
//   err         out  1   high with a done pulse when transaction timed out
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; starve_cnt, gap_cnt, tmo_cnt 0.
//   All outputs registered. States: IDLE, LAUNCH, XFER, GAP.
//   IDLE: if no req, stay. Else grant per policy, latch cmd into mst_cmd,
//     set owner, go LAUNCH. Grant at clock edge N -> mst_wrt high N+1.
//   Policy: inert_req only -> inertial. a2d_req only -> A2D.
//     Both: A2D if starve_cnt == STARVE_LIMIT, else inertial.
//     starve_cnt++ on inertial grant with a2d_req high (saturates);
//     cleared on A2D grant or on any grant with a2d_req low.
//   LAUNCH: mst_wrt = 1 for exactly this one clock; go XFER, tmo_cnt = 0.
//   XFER: on mst_done -> rd_data <= mst_rd, err <= 0, owner's done pulses
//     next clock, go GAP. If tmo_cnt reaches TMO_CYCLES-1 first -> rd_data
//     unchanged, err <= 1, owner's done pulses, go GAP.
//   GAP: count GAP_CYCLES clocks, then IDLE; GAP_CYCLES=0 -> IDLE next clk.
//     owner and mst_cmd held through GAP (SS_n deassert settles).
//   err valid alongside done pulse; held until next completion.
//   mst_done outside XFER ignored. mst_done and timeout same clock -> done
//     wins (err = 0, data captured).
//   Requester dropping req mid-transfer: transaction completes, done still
//     pulses. Req still high when IDLE re-entered -> treated as new request.
//   Inputs sampled only in IDLE; cmd changes during a transfer have no effect.
//   rst_n assert mid-transfer: immediate return to reset values, no done
//     pulse; mst_wrt never re-issued after reset until a new grant.
// TESTING
//   inert_req alone, cmd 16'hA2xx, mst_done+mst_rd=16'h1234 after 20 clks ->
//     mst_wrt one clk, owner 0, inert_done one clk later, rd_data 16'h1234.
//   Both reqs held continuously, STARVE_LIMIT=3 -> grant order I,I,I,A,I,I,I,A;
//     owner toggles accordingly; GAP_CYCLES idle clocks between each.
//   a2d_req only, mst_done never returned -> a2d_done + err=1 after
//     TMO_CYCLES clks in XFER; rd_data unchanged; next request served.
//   mst_done pulsed in IDLE/GAP -> no done pulse, rd_data unchanged.
//   rst_n low during XFER -> all outputs 0 asynchronously, no done pulse;
//     after release, pending req re-granted with fresh mst_wrt.
//   mst_done coincident with timeout clock -> done pulse, err=0, data taken.

Source files
------------

// File: rtl/spi_bus_arb_if.sv
// Request/command/response bundle between the SPI arbiter, its two requesters and the SPI master.
interface spi_bus_arb_if;
  localparam int unsigned DW = 16;

  logic          inert_req;
  logic [DW-1:0] inert_cmd;
  logic          a2d_req;
  logic [DW-1:0] a2d_cmd;
  logic          mst_wrt;
  logic [DW-1:0] mst_cmd;
  logic          mst_done;
  logic [DW-1:0] mst_rd;
  logic          owner;
  logic          busy;
  logic          inert_done;
  logic          a2d_done;
  logic [DW-1:0] rd_data;
  logic          err;

  // Arbiter side
  modport slave (
    input  inert_req, inert_cmd, a2d_req, a2d_cmd, mst_done, mst_rd,
    output mst_wrt, mst_cmd, owner, busy, inert_done, a2d_done, rd_data, err
  );

  // Requester / SPI-master side
  modport master (
    output inert_req, inert_cmd, a2d_req, a2d_cmd, mst_done, mst_rd,
    input  mst_wrt, mst_cmd, owner, busy, inert_done, a2d_done, rd_data, err
  );
endinterface

// File: rtl/spi_bus_arb.sv
// Shares one 16-bit SPI master between the inertial and A2D interfaces.
// Inertial has priority; a starvation counter forces periodic A2D service.
module spi_bus_arb #(
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned STARVE_LIMIT = 3,
  parameter int unsigned TMO_CYCLES   = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_bus_arb_if.slave bus
);
  localparam int unsigned DW       = 16;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned STV_W    = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned TMO_W    = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
  localparam int unsigned TMO_LAST = (TMO_CYCLES > 1) ? TMO_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_XFER   = 2'd2,
    S_GAP    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [DW-1:0]    mst_cmd_q, mst_cmd_d;
  logic             mst_wrt_q, mst_wrt_d;
  logic             busy_q, busy_d;
  logic             inert_done_q, inert_done_d;
  logic             a2d_done_q, a2d_done_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             err_q, err_d;
  logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic any_req;
  logic grant_a2d;
  logic tmo_hit;
  logic gap_hit;

  assign any_req   = bus.inert_req | bus.a2d_req;
  // A2D wins when alone, or when inertial has hogged the bus STARVE_LIMIT times
  assign grant_a2d = bus.a2d_req &
                     (~bus.inert_req | (starve_cnt_q == STV_W'(STARVE_LIMIT)));
  assign tmo_hit   = (tmo_cnt_q == TMO_W'(TMO_LAST));
  assign gap_hit   = (GAP_CYCLES <= 1) | (gap_cnt_q == GAP_W'(GAP_LAST));

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      mst_cmd_q    <= '0;
      mst_wrt_q    <= 1'b0;
      busy_q       <= 1'b0;
      inert_done_q <= 1'b0;
      a2d_done_q   <= 1'b0;
      rd_data_q    <= '0;
      err_q        <= 1'b0;
      starve_cnt_q <= '0;
      gap_cnt_q    <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mst_cmd_q    <= mst_cmd_d;
      mst_wrt_q    <= mst_wrt_d;
      busy_q       <= busy_d;
      inert_done_q <= inert_done_d;
      a2d_done_q   <= a2d_done_d;
      rd_data_q    <= rd_data_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_XFER;
      S_XFER:   if (bus.mst_done || tmo_hit) state_d = S_GAP;
      S_GAP:    if (gap_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and counter logic; every output is the registered image of *_d
  always_comb begin
    owner_d      = owner_q;
    mst_cmd_d    = mst_cmd_q;
    mst_wrt_d    = 1'b0;
    busy_d       = (state_d != S_IDLE);
    inert_done_d = 1'b0;
    a2d_done_d   = 1'b0;
    rd_data_d    = rd_data_q;
    err_d        = err_q;
    starve_cnt_d = starve_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d   = grant_a2d;
          mst_cmd_d = grant_a2d ? bus.a2d_cmd : bus.inert_cmd;
          mst_wrt_d = 1'b1;
          if (grant_a2d || !bus.a2d_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q != STV_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
          end
        end
      end
      S_LAUNCH: begin
        tmo_cnt_d = '0;
      end
      S_XFER: begin
        // A done pulse on the timeout clock still counts as a good completion
        if (bus.mst_done || tmo_hit) begin
          if (bus.mst_done) begin
            rd_data_d = bus.mst_rd;
            err_d     = 1'b0;
          end else begin
            err_d     = 1'b1;
          end
          inert_done_d = ~owner_q;
          a2d_done_d   = owner_q;
          gap_cnt_d    = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      S_GAP: begin
        if (!gap_hit) gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: ;
    endcase
  end

  assign bus.mst_wrt    = mst_wrt_q;
  assign bus.mst_cmd    = mst_cmd_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = busy_q;
  assign bus.inert_done = inert_done_q;
  assign bus.a2d_done   = a2d_done_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_spi_bus_arb.sv
// Bench for spi_bus_arb: directed scenarios plus random traffic checked against
// a transaction-level timing/policy model.
module tb_spi_bus_arb;
  localparam int unsigned GAP = 4;
  localparam int unsigned SL  = 3;
  localparam int unsigned TMO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_bus_arb_if bus ();

  spi_bus_arb #(.GAP_CYCLES(GAP), .STARVE_LIMIT(SL), .TMO_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Values currently driven, i.e. what the next clock edge will sample
  logic        d_ireq, d_areq;
  logic [15:0] d_icmd, d_acmd;

  // Transaction-level model
  bit          gnt_next, last_busy, outstanding, resp_none, m_owner, m_err;
  logic [15:0] m_cmd, m_rd, resp_data, fix_rd_val;
  int          wrt_cyc, done_cyc, free_cyc, resp_d, starve;
  int          req_mode, dly_mode, spur_pct;
  bit          fix_rd;
  int          n_idone, n_adone;
  bit          glog[$];
  int          gwrt[$];
  int          gdone[$];
  bit          exp_pat [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    bus.inert_req = d_ireq;
    bus.a2d_req   = d_areq;
    bus.inert_cmd = d_icmd;
    bus.a2d_cmd   = d_acmd;
    gnt_next      = !last_busy && (d_ireq || d_areq);
  endtask

  // One clock: sample and check, advance the model, then drive the next inputs
  task automatic step();
    bit exp_wrt, exp_done, exp_busy, a2d_g;
    int r;
    @(posedge clk);
    #1;
    cyc++;
    exp_wrt = gnt_next;
    if (gnt_next) begin
      a2d_g = d_areq && (!d_ireq || starve == int'(SL));
      if (a2d_g || !d_areq) starve = 0;
      else if (starve < int'(SL)) starve++;
      m_owner     = a2d_g;
      m_cmd       = a2d_g ? d_acmd : d_icmd;
      outstanding = 1'b1;
      wrt_cyc     = cyc;
      resp_none   = 1'b0;
      resp_d      = 0;
      if (dly_mode > 0) resp_d = dly_mode;
      else if (dly_mode == 0) resp_none = 1'b1;
      else begin
        r = int'($urandom_range(0, 11));
        if (r == 0) resp_none = 1'b1;
        else if (r == 1) resp_d = int'(TMO);
        else resp_d = int'($urandom_range(1, 24));
      end
      done_cyc = cyc + (resp_none ? int'(TMO) : resp_d) + 1;
      glog.push_back(a2d_g);
      gwrt.push_back(cyc);
    end
    exp_done = outstanding && (cyc == done_cyc);
    if (exp_done) begin
      if (resp_none) m_err = 1'b1;
      else begin
        m_err = 1'b0;
        m_rd  = resp_data;
      end
      outstanding = 1'b0;
      free_cyc    = cyc + int'(GAP);
      gdone.push_back(cyc);
    end
    exp_busy = outstanding || (cyc < free_cyc);

    check_eq("mst_wrt",    32'(bus.mst_wrt),    32'(exp_wrt));
    check_eq("owner",      32'(bus.owner),      32'(m_owner));
    check_eq("busy",       32'(bus.busy),       32'(exp_busy));
    check_eq("inert_done", 32'(bus.inert_done), 32'(exp_done && !m_owner));
    check_eq("a2d_done",   32'(bus.a2d_done),   32'(exp_done && m_owner));
    check_eq("rd_data",    32'(bus.rd_data),    32'(m_rd));
    check_eq("err",        32'(bus.err),        32'(m_err));
    check_eq("mst_cmd",    32'(bus.mst_cmd),    32'(m_cmd));
    if (bus.inert_done) n_idone++;
    if (bus.a2d_done)   n_adone++;

    // SPI master: one response per launch, stray pulses only when nothing is in flight
    bus.mst_done = 1'b0;
    bus.mst_rd   = 16'($urandom);
    if (outstanding && !resp_none && cyc == wrt_cyc + resp_d) begin
      bus.mst_done = 1'b1;
      if (fix_rd) bus.mst_rd = fix_rd_val;
      resp_data = bus.mst_rd;
    end else if (!outstanding && int'($urandom_range(0, 99)) < spur_pct) begin
      bus.mst_done = 1'b1;
    end

    // Requesters
    if (req_mode == 1) begin
      d_ireq = 1'b1;
      d_areq = 1'b1;
    end else begin
      if (exp_done) begin
        if (m_owner) d_areq = 1'b0;
        else d_ireq = 1'b0;
      end
      if (req_mode == 0) begin
        if (outstanding && $urandom_range(0, 31) == 0) begin
          if (m_owner) d_areq = 1'b0;
          else d_ireq = 1'b0;
        end
        if (!d_ireq && !exp_done && !(outstanding && !m_owner) && $urandom_range(0, 3) == 0)
          d_ireq = 1'b1;
        if (!d_areq && !exp_done && !(outstanding && m_owner) && $urandom_range(0, 3) == 0)
          d_areq = 1'b1;
        d_icmd = 16'($urandom);
        d_acmd = 16'($urandom);
      end
    end
    last_busy = exp_busy;
    drive();
  endtask

  task automatic settle();
    int guard = 0;
    while ((outstanding || cyc < free_cyc) && guard < 300) begin
      step();
      guard++;
    end
    check_eq("settle_bound", 32'(guard < 300), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wrt"},   32'(bus.mst_wrt),    32'd0);
    check_eq({tag, "_cmd"},   32'(bus.mst_cmd),    32'd0);
    check_eq({tag, "_owner"}, 32'(bus.owner),      32'd0);
    check_eq({tag, "_busy"},  32'(bus.busy),       32'd0);
    check_eq({tag, "_idone"}, 32'(bus.inert_done), 32'd0);
    check_eq({tag, "_adone"}, 32'(bus.a2d_done),   32'd0);
    check_eq({tag, "_rd"},    32'(bus.rd_data),    32'd0);
    check_eq({tag, "_err"},   32'(bus.err),        32'd0);
  endtask

  initial begin
    int base, dbase, guard, i0, a0;
    logic [15:0] rd_before;

    d_ireq = 1'b0; d_areq = 1'b0; d_icmd = '0; d_acmd = '0;
    bus.mst_done = 1'b0; bus.mst_rd = '0;
    gnt_next = 1'b0; last_busy = 1'b0; outstanding = 1'b0; resp_none = 1'b0;
    m_owner = 1'b0; m_err = 1'b0; m_cmd = '0; m_rd = '0; resp_data = '0;
    fix_rd = 1'b0; fix_rd_val = '0;
    wrt_cyc = 0; done_cyc = 0; free_cyc = 0; resp_d = 0; starve = 0;
    req_mode = 2; dly_mode = -1; spur_pct = 0; n_idone = 0; n_adone = 0;
    drive();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    drive();

    // Single inertial read, response after 20 clocks
    d_ireq = 1'b1; d_icmd = 16'hA25C; dly_mode = 20;
    fix_rd = 1'b1; fix_rd_val = 16'h1234;
    i0 = n_idone;
    drive();
    repeat (30) step();
    check_eq("t1_ndone", 32'(n_idone), 32'(i0 + 1));
    check_eq("t1_rd",    32'(bus.rd_data), 32'h1234);
    check_eq("t1_owner", 32'(glog[glog.size() - 1]), 32'd0);
    fix_rd = 1'b0;
    settle();

    // Both requesters held: grant order and inter-transaction spacing
    req_mode = 1; dly_mode = 6;
    d_ireq = 1'b1; d_areq = 1'b1;
    drive();
    base = glog.size(); dbase = gdone.size(); guard = 0;
    while (glog.size() < base + 8 && guard < 500) begin
      step();
      guard++;
    end
    check_eq("t2_bound", 32'(glog.size() >= base + 8), 32'd1);
    for (int k = 0; k < 8; k++)
      if (base + k < glog.size())
        check_eq($sformatf("t2_grant%0d", k), 32'(glog[base + k]), 32'(exp_pat[k]));
    for (int k = 0; k < 7; k++)
      if (dbase + k < gdone.size() && base + k + 1 < gwrt.size())
        check_eq($sformatf("t2_gap%0d", k), 32'(gwrt[base + k + 1] - gdone[dbase + k]),
                 32'(GAP + 1));
    req_mode = 2; d_ireq = 1'b0; d_areq = 1'b0;
    drive();
    settle();

    // A2D request with no response: timeout, then next request still served
    d_areq = 1'b1; dly_mode = 0;
    a0 = n_adone; i0 = n_idone; rd_before = m_rd;
    drive();
    repeat (TMO + 3) step();
    check_eq("t3_adone", 32'(n_adone), 32'(a0 + 1));
    check_eq("t3_err",   32'(bus.err), 32'd1);
    check_eq("t3_rd",    32'(bus.rd_data), 32'(rd_before));
    d_ireq = 1'b1; dly_mode = 5;
    drive();
    repeat (20) step();
    check_eq("t3_next_idone", 32'(n_idone), 32'(i0 + 1));
    check_eq("t3_next_err",   32'(bus.err), 32'd0);
    settle();

    // Stray mst_done pulses while idle
    spur_pct = 50; i0 = n_idone; a0 = n_adone; rd_before = m_rd;
    repeat (20) step();
    check_eq("t4_idone", 32'(n_idone), 32'(i0));
    check_eq("t4_adone", 32'(n_adone), 32'(a0));
    check_eq("t4_rd",    32'(bus.rd_data), 32'(rd_before));
    spur_pct = 0;

    // Response on the timeout clock
    d_ireq = 1'b1; dly_mode = int'(TMO);
    fix_rd = 1'b1; fix_rd_val = 16'hBEEF;
    drive();
    repeat (TMO + 4) step();
    check_eq("t5_rd",  32'(bus.rd_data), 32'hBEEF);
    check_eq("t5_err", 32'(bus.err), 32'd0);
    fix_rd = 1'b0;
    settle();

    // Reset during XFER, pending request re-granted afterwards
    d_areq = 1'b1; dly_mode = 0;
    drive();
    repeat (10) step();
    a0 = n_adone;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    bus.mst_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
      check_eq("t6_hold_busy", 32'(bus.busy), 32'd0);
      check_eq("t6_hold_wrt",  32'(bus.mst_wrt), 32'd0);
      check_eq("t6_hold_done", 32'(bus.a2d_done | bus.inert_done), 32'd0);
    end
    outstanding = 1'b0; free_cyc = cyc; starve = 0; last_busy = 1'b0;
    m_owner = 1'b0; m_err = 1'b0; m_rd = '0; m_cmd = '0;
    dly_mode = 8;
    rst_n = 1'b1;
    drive();
    base = glog.size();
    repeat (20) step();
    check_eq("t6_regrant",       32'(glog.size()), 32'(base + 1));
    check_eq("t6_regrant_owner", 32'(glog[glog.size() - 1]), 32'd1);
    check_eq("t6_adone",         32'(n_adone), 32'(a0 + 1));
    settle();

    // Random traffic
    req_mode = 0; dly_mode = -1; spur_pct = 10;
    repeat (3000) step();
    req_mode = 2; d_ireq = 1'b0; d_areq = 1'b0;
    drive();
    settle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end
endmodule
